seq_divider: RTL

- Multi-cycle restoring integer divider for the EX stage of the pipeline CPU.
- Computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, at one quotient bit per clock.
- Serves the MIPS-style DIV/DIVU path. Its HI/LO outputs feed the HI/LO registers.
- The hazard unit stalls the pipeline on busy until done pulses.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 22 ++
 rtl/seq_divider.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int MAX_W     = 64;

    // Two's-complement magnitude/negation on a zero-extended operand; caller truncates.
    function automatic logic [MAX_W-1:0] twos_abs(input logic [MAX_W-1:0] v, input logic neg);
        logic [MAX_W-1:0] res;
        if (neg) begin
            res = ~v + {{(MAX_W-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    assign shifted_s = {r_in, bit_in};
    assign diff_s    = shifted_s - {1'b0, d_in};

    // r_in < d_in keeps shifted_s - d_in below 2^WIDTH, so the top bit is a pure borrow.
    assign q_bit = ~diff_s[WIDTH];
    assign r_out = q_bit ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider producing one quotient bit per clock.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] dvd_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH-1:0] step_r_s;
    logic             step_q_s;
    logic             dvd_neg_s;
    logic             dsr_neg_s;
    logic [WIDTH-1:0] dvd_abs_s;
    logic [WIDTH-1:0] dsr_abs_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    assign dvd_neg_s = is_signed & dividend[WIDTH-1];
    assign dsr_neg_s = is_signed & divisor[WIDTH-1];
    assign dvd_abs_s = WIDTH'(twos_abs(MAX_W'(dividend), dvd_neg_s));
    assign dsr_abs_s = WIDTH'(twos_abs(MAX_W'(divisor), dsr_neg_s));
    assign q_fix_s   = WIDTH'(twos_abs(MAX_W'(q_r), neg_q_r));
    assign r_fix_s   = WIDTH'(twos_abs(MAX_W'(r_r), neg_r_r));

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in   (r_r),
        .bit_in (q_r[WIDTH-1]),
        .d_in   (d_r),
        .r_out  (step_r_s),
        .q_bit  (step_q_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (divisor == {WIDTH{1'b0}}) ? ZERO : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = IDLE;
            ZERO:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs; busy stays high through the done cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            div_zero_r  <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_r != IDLE) || start;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        q_r     <= dvd_abs_s;
                        d_r     <= dsr_abs_s;
                        dvd_r   <= dividend;
                        r_r     <= {WIDTH{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        neg_q_r <= dvd_neg_s ^ dsr_neg_s;
                        neg_r_r <= dvd_neg_s;
                    end
                end
                RUN: begin
                    r_r   <= step_r_s;
                    q_r   <= {q_r[WIDTH-2:0], step_q_s};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    quotient_r  <= q_fix_s;
                    remainder_r <= r_fix_s;
                    div_zero_r  <= 1'b0;
                    done_r      <= 1'b1;
                end
                ZERO: begin
                    quotient_r  <= {WIDTH{1'b1}};
                    remainder_r <= dvd_r;
                    div_zero_r  <= 1'b1;
                    done_r      <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

endmodule
